axi2apb_ctrl: RTL

APB master sequencer for the AXI-to-APB bridge. It sits between the command queue (decoded AXI AR/AW commands) and the read/write response stages. It pops one command at a time and runs the APB SETUP/ACCESS phases. It waits for the matching response stage to report completion (finish_rd/finish_wr), and provides a pready timeout so a missing slave cannot hang the bridge.

---
 rtl/axi2apb_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axi2apb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axi2apb_ctrl
// Purpose  : APB master sequencer of the AXI-to-APB bridge. Pops one decoded
//            AXI command at a time from the command queue, runs the APB
//            SETUP/ACCESS phases, waits for the matching response stage to
//            finish, and forces an error completion when the slave never
//            raises pready.
// Ports    : clk, rstn (async, active-low)
//            cmd_empty, cmd_read, WVALID       - queue head status / write data
//            finish_wr, finish_rd              - response stage handshakes
//            cmd_pop                           - one-cycle queue pop
//            psel, penable, pwrite             - registered APB controls
//            pready, pslverr                   - APB slave response
//            pready_o, pslverr_o               - qualified response to stages
//            busy                              - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module axi2apb_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic cmd_empty,
  input  logic cmd_read,
  input  logic WVALID,
  input  logic finish_wr,
  input  logic finish_rd,
  output logic cmd_pop,
  output logic psel,
  output logic penable,
  output logic pwrite,
  input  logic pready,
  input  logic pslverr,
  output logic pready_o,
  output logic pslverr_o,
  output logic busy
);

  // Counter wide enough to hold TIMEOUT itself; never narrower than 1 bit.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          C_TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SETUP     = 2'd1,
    S_ACCESS    = 2'd2,
    S_WAIT_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_psel;
  logic            r_penable;
  logic            r_pwrite;
  logic            r_hold;
  logic [CW-1:0]   r_cnt;
  logic            w_psel_nxt;
  logic            w_penable_nxt;
  logic            w_pwrite_nxt;
  logic            w_hold_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_start;
  logic            w_finish;
  logic            w_to_hit;

  // The queue head only refreshes on the edge after cmd_pop, so the first
  // IDLE cycle after a completed command is a settle cycle (r_hold) and the
  // head is sampled one cycle later. This yields the 5-cycle command cadence.
  assign w_start  = !r_hold && !cmd_empty && (cmd_read || WVALID);

  // Direction comes from the latched pwrite, never from the live queue head.
  assign w_finish = r_pwrite ? finish_wr : finish_rd;

  assign w_to_hit = C_TO_EN && (r_state == S_ACCESS) &&
                    (r_cnt == C_CNT_LAST) && !pready;

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign busy      = (r_state != S_IDLE);
  assign cmd_pop   = (r_state == S_WAIT_RESP) && w_finish;
  // psel & penable is only true in ACCESS, so pready/pslverr are ignored
  // everywhere else.
  assign pready_o  = r_psel & r_penable & (pready | w_to_hit);
  assign pslverr_o = r_psel & r_penable &
                     ((pready & pslverr) | (w_to_hit & ~pready));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_hold    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_hold    <= w_hold_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_hold_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt   = S_SETUP;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = ~cmd_read;
        end
      end
      S_SETUP: begin
        w_state_nxt   = S_ACCESS;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end
      S_ACCESS: begin
        if (pready || w_to_hit) begin
          w_state_nxt   = S_WAIT_RESP;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
        end else if (r_cnt != C_CNT_MAX) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_WAIT_RESP: begin
        if (w_finish) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
